regfile_write_arbiter: RTL and testbench

Sequences the single write port of the 32 x 32-bit register file between two writeback requesters (A and B) using round-robin arbitration. It also provides a software-triggered clear sequence that zeroes registers 1..31 without asserting the regfile's global `ctrl_reset`. The block sits between the writeback stages and the regfile's `ctrl_writeEn` / `ctrl_writeReg` / `data_writeReg` inputs; the read ports are untouched.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_write_arbiter_rr_arb2.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the regfile write-port arbiter.
package regfile_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ZERO_REG       = 0;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: the priority pointer moves to the loser after each transfer.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic valid_a,
  input  logic valid_b,
  output logic ready_a,
  output logic ready_b,
  output logic prio_a
);

  // Ready depends only on the other side's valid and the pointer, never on the own valid.
  assign ready_a = enable & (prio_a | !valid_b);
  assign ready_b = enable & (!prio_a | !valid_a);

  // Pointer update: hand priority to the non-granted side, hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_a <= 1'b1;
    end else if (valid_a && ready_a) begin
      prio_a <= 1'b0;
    end else if (valid_b && ready_b) begin
      prio_a <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sequences the regfile write port between two writeback requesters and a software clear.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      req_a_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req_a_reg,
  input  logic [DATA_WIDTH-1:0]     req_a_data,
  output logic                      req_a_ready,
  input  logic                      req_b_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req_b_reg,
  input  logic [DATA_WIDTH-1:0]     req_b_data,
  output logic                      req_b_ready,
  input  logic                      ctrl_clear,
  output logic                      clear_busy,
  output logic                      ctrl_writeEn,
  output logic [REG_ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]     data_writeReg
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX  = REG_ADDR_WIDTH'(ZERO_REG);
  localparam logic [REG_ADDR_WIDTH-1:0] FIRST_CLR = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_CLR  = REG_ADDR_WIDTH'(NUM_REGS - 1);

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      arb_en;
  logic                      prio_a;
  logic                      xfer;
  logic                      pick_a;
  logic [REG_ADDR_WIDTH-1:0] sel_reg;

  // Requesters only compete in ARB on cycles without a clear request.
  assign arb_en = (state_q == ARB) && !ctrl_clear;

  rr_arb2 u_arb (
    .clk     (clock),
    .rst     (ctrl_reset),
    .enable  (arb_en),
    .valid_a (req_a_valid),
    .valid_b (req_b_valid),
    .ready_a (req_a_ready),
    .ready_b (req_b_ready),
    .prio_a  (prio_a)
  );

  // At most one side can transfer per cycle; pick_a names which one it is.
  assign xfer    = (req_a_valid & req_a_ready) | (req_b_valid & req_b_ready);
  assign pick_a  = req_a_valid & (prio_a | !req_b_valid);
  assign sel_reg = pick_a ? req_a_reg : req_b_reg;

  // Next-state and next write-port contents.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ARB: begin
        if (ctrl_clear) begin
          state_d = CLEAR;
          idx_d   = FIRST_CLR;
        end else if (xfer) begin
          wr_en_d   = (sel_reg != ZERO_IDX);
          wr_reg_d  = sel_reg;
          wr_data_d = pick_a ? req_a_data : req_b_data;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_reg_d  = idx_q;
        wr_data_d = '0;
        idx_d     = idx_q + REG_ADDR_WIDTH'(1);
        if (idx_q == LAST_CLR) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State, clear index and write-port registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q   <= ARB;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign clear_busy    = (state_q == CLEAR);
  assign ctrl_writeEn  = wr_en_q;
  assign ctrl_writeReg = wr_reg_q;
  assign data_writeReg = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter with a behavioural regfile behind the port.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [4:0]  req_a_reg = '0, req_b_reg = '0;
  logic [31:0] req_a_data = '0, req_b_data = '0;
  logic        req_a_ready, req_b_ready;
  logic        ctrl_clear = 1'b0;
  logic        clear_busy;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [32] = '{default: 32'h0};
  logic [31:0] mrf [32];

  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        bv; logic [4:0] br; logic [31:0] bd;
    logic        ra; logic rb; logic en; logic [4:0] wreg; logic [31:0] wdata;
  } vec_t;
  vec_t tbl [8];

  regfile_write_arbiter dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .req_a_valid   (req_a_valid),
    .req_a_reg     (req_a_reg),
    .req_a_data    (req_a_data),
    .req_a_ready   (req_a_ready),
    .req_b_valid   (req_b_valid),
    .req_b_reg     (req_b_reg),
    .req_b_data    (req_b_data),
    .req_b_ready   (req_b_ready),
    .ctrl_clear    (ctrl_clear),
    .clear_busy    (clear_busy),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg)
  );

  always #5 clock = ~clock;

  // Regfile model: captures every enabled write, including any stray write to index 0.
  always @(posedge clock) begin
    if (ctrl_writeEn === 1'b1) rf[ctrl_writeReg] <= data_writeReg;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd,
                              input logic ra, input logic rb, input logic en,
                              input logic [4:0] wreg, input logic [31:0] wdata);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.ra = ra; v.rb = rb; v.en = en; v.wreg = wreg; v.wdata = wdata;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset = 1'b1; req_a_valid = 1'b0; req_b_valid = 1'b0; ctrl_clear = 1'b0;
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  task automatic fill_index();
    for (int k = 1; k < 32; k++) begin
      @(negedge clock);
      req_a_valid = 1'b1; req_a_reg = 5'(k); req_a_data = 32'(k);
    end
    @(negedge clock);
    req_a_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
  endtask

  initial begin
    int busy_cnt;
    int bad;
    logic m_prio, acc_a, acc_b, e_ra, e_rb, ga, gb, e_en;
    logic [4:0] e_reg;
    logic [31:0] e_data;

    // Reset state
    do_reset();
    #1;
    chk("rst_en", 32'(ctrl_writeEn), 32'd0);
    chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_ready_a", 32'(req_a_ready), 32'd1);
    chk("rst_ready_b", 32'(req_b_ready), 32'd1);

    // Fresh reset, both continuously valid: A first, then alternating
    do_reset();
    @(negedge clock);
    req_a_valid = 1'b1; req_a_reg = 5'd3; req_a_data = 32'h11;
    req_b_valid = 1'b1; req_b_reg = 5'd3; req_b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("alt_en", 32'(ctrl_writeEn), 32'd1);
      chk("alt_data", data_writeReg, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    @(negedge clock);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(posedge clock); #1;
    chk("alt_last_wins", rf[3], 32'h22);

    // Table-driven vectors from a fresh reset (priority starts at A)
    tbl[0] = mk(1'b1, 5'd5,  32'h0000DEAD, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b1, 5'd5,  32'h0000DEAD);
    tbl[1] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 1'b0, 5'd0,  32'h0);
    tbl[2] = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd3,  32'h22,     1'b0, 1'b1, 1'b1, 5'd3,  32'h22);
    tbl[3] = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd3,  32'h22,     1'b1, 1'b0, 1'b1, 5'd3,  32'h11);
    tbl[4] = mk(1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 1'b0, 5'd0,  32'h0);
    tbl[5] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hABCD,   1'b0, 1'b1, 1'b1, 5'd7,  32'hABCD);
    tbl[6] = mk(1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b1, 5'd9,  32'h99);
    tbl[7] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1010,   1'b0, 1'b1, 1'b1, 5'd10, 32'h1010);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      req_a_valid = tbl[i].av; req_a_reg = tbl[i].ar; req_a_data = tbl[i].ad;
      req_b_valid = tbl[i].bv; req_b_reg = tbl[i].br; req_b_data = tbl[i].bd;
      #1;
      chk($sformatf("vec%0d_ready_a", i), 32'(req_a_ready), 32'(tbl[i].ra));
      chk($sformatf("vec%0d_ready_b", i), 32'(req_b_ready), 32'(tbl[i].rb));
      @(posedge clock); #1;
      chk($sformatf("vec%0d_en", i), 32'(ctrl_writeEn), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_reg", i), 32'(ctrl_writeReg), 32'(tbl[i].wreg));
        chk($sformatf("vec%0d_data", i), data_writeReg, tbl[i].wdata);
      end
    end
    @(negedge clock);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(posedge clock); #1;
    chk("rf5", rf[5], 32'h0000DEAD);
    chk("rf3", rf[3], 32'h11);
    chk("rf0", rf[0], 32'h0);
    chk("rf7", rf[7], 32'hABCD);
    chk("rf10", rf[10], 32'h1010);

    // Randomized traffic against the spec-level model
    do_reset();
    m_prio = 1'b1; acc_a = 1'b0; acc_b = 1'b0;
    for (int r = 0; r < 32; r++) mrf[r] = rf[r];
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (!req_a_valid || acc_a) begin
        req_a_valid = ($urandom_range(0, 3) != 0);
        req_a_reg = 5'($urandom_range(0, 31)); req_a_data = $urandom;
      end
      if (!req_b_valid || acc_b) begin
        req_b_valid = ($urandom_range(0, 3) != 0);
        req_b_reg = 5'($urandom_range(0, 31)); req_b_data = $urandom;
      end
      #1;
      e_ra = m_prio | !req_b_valid;
      e_rb = !m_prio | !req_a_valid;
      chk("rnd_ready_a", 32'(req_a_ready), 32'(e_ra));
      chk("rnd_ready_b", 32'(req_b_ready), 32'(e_rb));
      ga = req_a_valid & e_ra;
      gb = req_b_valid & e_rb & !ga;
      e_reg  = ga ? req_a_reg : req_b_reg;
      e_data = ga ? req_a_data : req_b_data;
      e_en   = (ga | gb) && (e_reg != 5'd0);
      if (e_en) mrf[e_reg] = e_data;
      if (ga) m_prio = 1'b0;
      else if (gb) m_prio = 1'b1;
      acc_a = ga; acc_b = gb;
      @(posedge clock); #1;
      chk("rnd_en", 32'(ctrl_writeEn), 32'(e_en));
      if (e_en) begin
        chk("rnd_reg", 32'(ctrl_writeReg), 32'(e_reg));
        chk("rnd_data", data_writeReg, e_data);
      end
    end
    @(negedge clock);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(posedge clock); #1;
    bad = 0;
    for (int r = 0; r < 32; r++) if (rf[r] !== mrf[r]) bad++;
    chk("rnd_regfile_mismatches", 32'(bad), 32'd0);

    // Clear sequence with a second clear pulse and A held valid throughout
    fill_index();
    @(negedge clock);
    ctrl_clear = 1'b1;
    req_a_valid = 1'b1; req_a_reg = 5'd20; req_a_data = 32'h5A5A;
    #1;
    chk("clr_N_ready_a", 32'(req_a_ready), 32'd0);
    busy_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clock); #1;
      ctrl_clear = (c == 10);
      #1;
      if (clear_busy === 1'b1) busy_cnt++;
      chk($sformatf("clr_busy_c%0d", c), 32'(clear_busy), (c <= 31) ? 32'd1 : 32'd0);
      if (c <= 31) begin
        chk($sformatf("clr_ready_a_c%0d", c), 32'(req_a_ready), 32'd0);
        chk($sformatf("clr_ready_b_c%0d", c), 32'(req_b_ready), 32'd0);
      end else begin
        chk("clr_ready_a_reassert", 32'(req_a_ready), 32'd1);
      end
      if (c >= 2) begin
        chk($sformatf("clr_en_c%0d", c), 32'(ctrl_writeEn), 32'd1);
        chk($sformatf("clr_reg_c%0d", c), 32'(ctrl_writeReg), 32'(c - 1));
        chk($sformatf("clr_data_c%0d", c), data_writeReg, 32'd0);
      end
    end
    ctrl_clear = 1'b0;
    @(posedge clock); #1;
    req_a_valid = 1'b0;
    chk("clr_grant_en", 32'(ctrl_writeEn), 32'd1);
    chk("clr_grant_reg", 32'(ctrl_writeReg), 32'd20);
    chk("clr_grant_data", data_writeReg, 32'h5A5A);
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    @(posedge clock); #1;
    bad = 0;
    for (int r = 1; r < 32; r++) if (rf[r] !== ((r == 20) ? 32'h5A5A : 32'h0)) bad++;
    chk("clr_regs_zero", 32'(bad), 32'd0);

    // Reset taking effect at N+15 of a clear
    fill_index();
    @(negedge clock);
    ctrl_clear = 1'b1;
    @(posedge clock); #1;
    ctrl_clear = 1'b0;
    repeat (13) @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    @(posedge clock); #1;
    ctrl_reset = 1'b0;
    chk("abort_en", 32'(ctrl_writeEn), 32'd0);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    bad = 0;
    for (int r = 1; r < 32; r++) if (rf[r] !== ((r <= 13) ? 32'h0 : 32'(r))) bad++;
    chk("abort_partial_regs", 32'(bad), 32'd0);
    req_a_valid = 1'b1; req_a_reg = 5'd2; req_a_data = 32'h77;
    req_b_valid = 1'b1; req_b_reg = 5'd2; req_b_data = 32'h88;
    #1;
    chk("abort_prio_ready_a", 32'(req_a_ready), 32'd1);
    chk("abort_prio_ready_b", 32'(req_b_ready), 32'd0);
    @(posedge clock); #1;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    chk("abort_first_data", data_writeReg, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
